counter20: RTL and testbench



---
 rtl/counter20.sv | 48 ++++
 tb/tb_counter20.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/counter20.sv
// counter20: enable-gated binary up-counter with terminal count and sticky wrap flag.
// Counts 0..MAX_VAL and wraps to zero; tc flags the cycle whose closing edge wraps.
module counter20 #(
  parameter int unsigned            WIDTH   = 20,
  parameter logic [WIDTH-1:0]       MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped
);

  // Reject illegal parameterisations at elaboration time.
  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("counter20: WIDTH must be in 2..32");
    end
    if (MAX_VAL == '0) begin : g_bad_max
      $error("counter20: MAX_VAL must be at least 1");
    end
  endgenerate

  logic at_max;

  // Terminal value decode, shared by tc and the wrap path.
  assign at_max = (count == MAX_VAL);

  // Terminal count is combinational so consumers see it on the wrapping edge itself.
  assign tc = at_max & en;

  // Counter and sticky wrap flag; reset clears both asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      wrapped <= 1'b0;
    end else if (en) begin
      if (at_max) begin
        count   <= '0;
        wrapped <= 1'b1;
      end else begin
        count   <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_counter20.sv
// tb_counter20: directed and randomized checks of counter20 against an arithmetic model.
// Three instances: default (20-bit), WIDTH=4/MAX_VAL=9, and WIDTH=12 full-range.
module tb_counter20;

  localparam int unsigned NI = 3;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        en    = 1'b0;

  logic [19:0] count_d;
  logic [3:0]  count_s;
  logic [11:0] count_f;
  logic        tc_d, tc_s, tc_f;
  logic        wrapped_d, wrapped_s, wrapped_f;

  counter20 u_d (
    .clk(clk), .reset(reset), .en(en),
    .count(count_d), .tc(tc_d), .wrapped(wrapped_d)
  );

  counter20 #(.WIDTH(4), .MAX_VAL(4'd9)) u_s (
    .clk(clk), .reset(reset), .en(en),
    .count(count_s), .tc(tc_s), .wrapped(wrapped_s)
  );

  counter20 #(.WIDTH(12)) u_f (
    .clk(clk), .reset(reset), .en(en),
    .count(count_f), .tc(tc_f), .wrapped(wrapped_f)
  );

  always #5 clk = ~clk;

  // Reference model: counter value and wrap flag per instance, pure modular arithmetic.
  longint unsigned maxv [NI] = '{64'd1048575, 64'd9, 64'd4095};
  longint unsigned mc   [NI];
  longint unsigned mw   [NI];

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint unsigned obs_count(input int i);
    case (i)
      0:       return 64'(count_d);
      1:       return 64'(count_s);
      default: return 64'(count_f);
    endcase
  endfunction

  function automatic longint unsigned obs_tc(input int i);
    case (i)
      0:       return 64'(tc_d);
      1:       return 64'(tc_s);
      default: return 64'(tc_f);
    endcase
  endfunction

  function automatic longint unsigned obs_wrapped(input int i);
    case (i)
      0:       return 64'(wrapped_d);
      1:       return 64'(wrapped_s);
      default: return 64'(wrapped_f);
    endcase
  endfunction

  task automatic check_state(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_count%0d", tag, i), obs_count(i), mc[i]);
      check($sformatf("%s_wrapped%0d", tag, i), obs_wrapped(i), mw[i]);
    end
  endtask

  // One clock: entered ~1ns after a rising edge; drive en, check tc, advance, check state.
  task automatic cycle(input logic e);
    en = e;
    #1;
    for (int i = 0; i < NI; i++)
      check($sformatf("tc%0d", i), obs_tc(i), ((mc[i] == maxv[i]) && en) ? 64'd1 : 64'd0);
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      if (!reset) begin
        mc[i] = 0;
        mw[i] = 0;
      end else if (en) begin
        if (mc[i] + 1 > maxv[i]) mw[i] = 1;
        mc[i] = (mc[i] + 1) % (maxv[i] + 1);
      end
    end
    #1;
    check_state("edge");
  endtask

  // Asynchronous reset pulse placed between edges; low_ns in 2..6 keeps it clear of the next edge.
  task automatic reset_pulse(input int unsigned low_ns);
    #1;
    reset = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      mc[i] = 0;
      mw[i] = 0;
    end
    check_state("async_rst");
    #(low_ns - 1);
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      mc[i] = 0;
      mw[i] = 0;
    end

    // Reset held for two edges with en high.
    #1;
    check_state("por");
    cycle(1'b1);
    cycle(1'b1);
    check("rst_hold_count", 64'(count_d), 64'd0);

    // Release and count 83 edges.
    reset = 1'b1;
    repeat (83) cycle(1'b1);
    check("count83", 64'(count_d), 64'd83);
    check("count83_wrapped", 64'(wrapped_d), 64'd0);

    // Enable low holds the value.
    repeat (20) cycle(1'b0);
    check("hold83", 64'(count_d), 64'd83);
    check("hold83_tc", 64'(tc_d), 64'd0);

    // Asynchronous reset mid-hold, then idle, then count 10.
    en = 1'b0;
    reset_pulse(3);
    repeat (80) cycle(1'b0);
    check("idle_after_rst", 64'(count_d), 64'd0);
    repeat (10) cycle(1'b1);
    check("count10", 64'(count_d), 64'd10);

    // Reset pulse while counting at 37.
    repeat (27) cycle(1'b1);
    check("count37", 64'(count_d), 64'd37);
    en = 1'b1;
    reset_pulse(5);
    check("pulse_zero", 64'(count_d), 64'd0);
    cycle(1'b1);
    check("first_after_pulse", 64'(count_d), 64'd1);

    // Small MAX_VAL wrap: 1..9 then 0, tc only at 9, wrapped sticks.
    en = 1'b1;
    reset_pulse(4);
    for (int k = 1; k <= 10; k++) begin
      check("s_tc_seq", 64'(tc_s), (k == 10) ? 64'd1 : 64'd0);
      cycle(1'b1);
      check("s_count_seq", 64'(count_s), 64'(k % 10));
      check("s_wrapped_seq", 64'(wrapped_s), (k >= 10) ? 64'd1 : 64'd0);
    end
    repeat (5) cycle(1'b0);
    check("s_wrapped_sticky", 64'(wrapped_s), 64'd1);

    // Full-range wrap on the 12-bit instance: 0xFFF -> 0x000.
    en = 1'b1;
    reset_pulse(4);
    repeat (4095) cycle(1'b1);
    check("f_at_max", 64'(count_f), 64'd4095);
    check("f_tc_at_max", 64'(tc_f), 64'd1);
    check("f_not_wrapped_yet", 64'(wrapped_f), 64'd0);
    cycle(1'b1);
    check("f_wrap_count", 64'(count_f), 64'd0);
    check("f_wrap_flag", 64'(wrapped_f), 64'd1);

    // Randomized enable with occasional asynchronous reset pulses.
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 299) == 0)
        reset_pulse($urandom_range(2, 6));
      cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
